// File: rtl/spram_burst_master.sv
// rtl/spram_burst_master.sv - burst read/write initiator for the spram single-port RAM
module spram_burst_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  in_clock,
    input  logic                  in_reset_n,
    input  logic                  in_cmd_valid,
    output logic                  out_cmd_ready,
    input  logic                  in_cmd_write,
    input  logic [ADDR_WIDTH-1:0] in_cmd_address,
    input  logic [LEN_WIDTH-1:0]  in_cmd_length,
    input  logic                  in_wdata_valid,
    output logic                  out_wdata_ready,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_rdata_valid,
    input  logic                  in_rdata_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_rdata_last,
    output logic                  out_done,
    output logic                  out_busy,
    output logic                  out_mem_enable,
    output logic                  out_mem_write,
    output logic [ADDR_WIDTH-1:0] out_mem_address,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;

    // Read pipeline: rd_strobe_q marks a read strobe currently on out_mem_*,
    // rd_return_q marks RAM data valid on in_mem_data this cycle.
    logic                  rd_strobe_q;
    logic                  rd_strobe_last_q;
    logic                  rd_return_q;
    logic                  rd_return_last_q;

    // Two-entry return FIFO; the head drives out_rdata directly.
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic                  cmd_fire;
    logic                  wdata_fire;
    logic                  pop;
    logic [2:0]            credit;
    logic                  issue;
    logic                  rd_start;
    logic                  rd_issue;
    logic                  rd_issue_last;

    assign out_cmd_ready   = in_reset_n && (state == ST_IDLE);
    assign out_wdata_ready = in_reset_n && (state == ST_WRITE);
    assign out_busy        = (state != ST_IDLE);
    assign out_rdata_valid = (fifo_count != 2'd0);
    assign out_rdata       = fifo_data[rd_ptr];
    assign out_rdata_last  = out_rdata_valid && fifo_last[rd_ptr];

    assign cmd_fire   = in_cmd_valid && out_cmd_ready;
    assign wdata_fire = in_wdata_valid && out_wdata_ready;
    assign pop        = out_rdata_valid && in_rdata_ready;

    // Every read on the bus or in the RAM pipe holds a FIFO slot, so the FIFO
    // can never be asked to take a third word.
    assign credit = 3'(fifo_count) + 3'(rd_strobe_q) + 3'(rd_return_q) - 3'(pop);
    assign issue  = (state == ST_READ) && (credit < 3'd2);

    // A read burst issues its first strobe straight from the accept cycle; the
    // pipeline and FIFO are always empty then, so no credit check is needed.
    assign rd_start      = cmd_fire && !in_cmd_write;
    assign rd_issue      = rd_start || issue;
    assign rd_issue_last = rd_start ? (in_cmd_length == '0) : (remaining == '0);

    // Burst sequencing and registered memory strobes.
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state           <= ST_IDLE;
            addr            <= '0;
            remaining       <= '0;
            out_mem_enable  <= 1'b0;
            out_mem_write   <= 1'b0;
            out_mem_address <= '0;
            out_mem_data    <= '0;
            out_done        <= 1'b0;
        end else begin
            out_mem_enable <= 1'b0;
            out_mem_write  <= 1'b0;
            out_done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (in_cmd_write) begin
                            addr      <= in_cmd_address;
                            remaining <= in_cmd_length;
                            state     <= ST_WRITE;
                        end else begin
                            out_mem_enable  <= 1'b1;
                            out_mem_address <= in_cmd_address;
                            addr            <= in_cmd_address + ADDR_WIDTH'(1);
                            remaining       <= in_cmd_length - LEN_WIDTH'(1);
                            state           <= (in_cmd_length == '0) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wdata_fire) begin
                        out_mem_enable  <= 1'b1;
                        out_mem_write   <= 1'b1;
                        out_mem_address <= addr;
                        out_mem_data    <= in_wdata;
                        addr            <= addr + ADDR_WIDTH'(1);
                        remaining       <= remaining - LEN_WIDTH'(1);
                        if (remaining == '0) begin
                            out_done <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        out_mem_enable  <= 1'b1;
                        out_mem_address <= addr;
                        addr            <= addr + ADDR_WIDTH'(1);
                        remaining       <= remaining - LEN_WIDTH'(1);
                        if (remaining == '0) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The tagged word is the last one issued, so its handshake
                    // means the pipe and FIFO are now empty.
                    if (pop && out_rdata_last) begin
                        out_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-latency tracking and the return FIFO; reset discards in-flight data.
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            rd_strobe_q      <= 1'b0;
            rd_strobe_last_q <= 1'b0;
            rd_return_q      <= 1'b0;
            rd_return_last_q <= 1'b0;
            fifo_data[0]     <= '0;
            fifo_data[1]     <= '0;
            fifo_last        <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            fifo_count       <= 2'd0;
        end else begin
            rd_strobe_q      <= rd_issue;
            rd_strobe_last_q <= rd_issue && rd_issue_last;
            rd_return_q      <= rd_strobe_q;
            rd_return_last_q <= rd_strobe_last_q;
            if (rd_return_q) begin
                fifo_data[wr_ptr] <= in_mem_data;
                fifo_last[wr_ptr] <= rd_return_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(rd_return_q) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_spram_burst_master.sv
// tb/tb_spram_burst_master.sv - randomized self-checking bench for spram_burst_master
module tb_spram_burst_master;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          in_clock = 1'b0;
    logic          in_reset_n;
    logic          in_cmd_valid;
    logic          out_cmd_ready;
    logic          in_cmd_write;
    logic [AW-1:0] in_cmd_address;
    logic [LW-1:0] in_cmd_length;
    logic          in_wdata_valid;
    logic          out_wdata_ready;
    logic [DW-1:0] in_wdata;
    logic          out_rdata_valid;
    logic          in_rdata_ready;
    logic [DW-1:0] out_rdata;
    logic          out_rdata_last;
    logic          out_done;
    logic          out_busy;
    logic          out_mem_enable;
    logic          out_mem_write;
    logic [AW-1:0] out_mem_address;
    logic [DW-1:0] out_mem_data;
    logic [DW-1:0] in_mem_data;

    spram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .in_clock        (in_clock),
        .in_reset_n      (in_reset_n),
        .in_cmd_valid    (in_cmd_valid),
        .out_cmd_ready   (out_cmd_ready),
        .in_cmd_write    (in_cmd_write),
        .in_cmd_address  (in_cmd_address),
        .in_cmd_length   (in_cmd_length),
        .in_wdata_valid  (in_wdata_valid),
        .out_wdata_ready (out_wdata_ready),
        .in_wdata        (in_wdata),
        .out_rdata_valid (out_rdata_valid),
        .in_rdata_ready  (in_rdata_ready),
        .out_rdata       (out_rdata),
        .out_rdata_last  (out_rdata_last),
        .out_done        (out_done),
        .out_busy        (out_busy),
        .out_mem_enable  (out_mem_enable),
        .out_mem_write   (out_mem_write),
        .out_mem_address (out_mem_address),
        .out_mem_data    (out_mem_data),
        .in_mem_data     (in_mem_data)
    );

    always #5 in_clock = ~in_clock;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } strobe_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic          ram_clear;
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    strobe_t       sq[$];
    word_t         rq[$];
    int            dq[$];
    logic [DW-1:0] wq[$];
    int            beat_cyc[$];
    strobe_t       mon_s;
    word_t         mon_w;
    logic          stall_prev = 1'b0;
    logic [DW:0]   held_word  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge in_clock) cyc <= cyc + 1;

    // spram model: registered read data, valid the cycle after the strobe
    always @(posedge in_clock) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            in_mem_data <= '0;
        end else if (out_mem_enable) begin
            if (out_mem_write) ram[out_mem_address] <= out_mem_data;
            else               in_mem_data <= ram[out_mem_address];
        end
    end

    // bus monitor: logs strobes, read handshakes and done pulses; checks hold rule
    always @(negedge in_clock) begin
        if (in_reset_n) begin
            if (out_mem_enable) begin
                mon_s.cyc = cyc; mon_s.we = out_mem_write;
                mon_s.a = out_mem_address; mon_s.d = out_mem_data;
                sq.push_back(mon_s);
            end
            if (out_rdata_valid && in_rdata_ready) begin
                mon_w.cyc = cyc; mon_w.d = out_rdata; mon_w.last = out_rdata_last;
                rq.push_back(mon_w);
            end
            if (out_done) dq.push_back(cyc);
            if (stall_prev) begin
                chk("hold_valid", out_rdata_valid, 1);
                chk("hold_word", {out_rdata_last, out_rdata}, held_word);
            end
            stall_prev <= out_rdata_valid && !in_rdata_ready;
            held_word  <= {out_rdata_last, out_rdata};
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic clear_logs();
        sq.delete(); rq.delete(); dq.delete(); beat_cyc.delete();
    endtask

    task automatic send_cmd(input logic w, input int a, input int len, output int acc);
        int   n;
        logic got;
        in_cmd_valid = 1'b1; in_cmd_write = w;
        in_cmd_address = a[AW-1:0]; in_cmd_length = len[LW-1:0];
        got = 1'b0; n = 0; acc = 0;
        while (!got && n < 50) begin
            @(negedge in_clock);
            if (out_cmd_ready) begin
                got = 1'b1; acc = cyc;
                chk("wready_in_accept", out_wdata_ready, 0);
            end
            @(posedge in_clock); #1;
            n++;
        end
        in_cmd_valid = 1'b0;
        chk("cmd_accept", got, 1);
    endtask

    task automatic run_write(input int a, input int len, input int gap_pct);
        int   acc, idx, n;
        logic fire;
        clear_logs();
        send_cmd(1'b1, a, len, acc);
        idx = 0; n = 0;
        while (idx <= len && n < 2000) begin
            in_wdata_valid = ($urandom_range(99) >= gap_pct);
            in_wdata = wq[idx];
            @(negedge in_clock);
            fire = in_wdata_valid && out_wdata_ready;
            if (fire) beat_cyc.push_back(cyc);
            @(posedge in_clock); #1;
            if (fire) idx++;
            n++;
        end
        in_wdata_valid = 1'b0;
        repeat (3) @(posedge in_clock); #1;
        chk("wr_beats", idx, len + 1);
        for (int i = 0; i <= len; i++) ref_mem[(a + i) % DEPTH] = wq[i];
        chk("wr_strobes", sq.size(), len + 1);
        for (int i = 0; i < sq.size() && i < beat_cyc.size() && i <= len; i++) begin
            chk("wr_strobe_cyc", sq[i].cyc, beat_cyc[i] + 1);
            chk("wr_strobe", {sq[i].we, sq[i].a, sq[i].d}, {1'b1, AW'((a + i) % DEPTH), wq[i]});
        end
        chk("wr_done_count", dq.size(), 1);
        if (dq.size() > 0 && beat_cyc.size() > len) chk("wr_done_cyc", dq[0], beat_cyc[len] + 1);
        chk("wr_idle", {out_busy, out_cmd_ready}, 2'b01);
    endtask

    // mode 0: ready always 1, mode 1: random ready, mode 2: ready 0 for stall_n cycles
    task automatic run_read(input int a, input int len, input int mode, input int stall_n);
        int acc, n, cnt;
        clear_logs();
        in_rdata_ready = (mode == 0);
        send_cmd(1'b0, a, len, acc);
        n = 0;
        while (dq.size() == 0 && n < 3000) begin
            if (mode == 0)      in_rdata_ready = 1'b1;
            else if (mode == 1) in_rdata_ready = ($urandom_range(1) == 1);
            else                in_rdata_ready = (n >= stall_n);
            @(negedge in_clock);
            @(posedge in_clock); #1;
            n++;
        end
        in_rdata_ready = 1'b1;
        repeat (2) @(posedge in_clock); #1;
        chk("rd_done_count", dq.size(), 1);
        chk("rd_strobes", sq.size(), len + 1);
        for (int i = 0; i < sq.size() && i <= len; i++)
            chk("rd_strobe", {sq[i].we, sq[i].a}, {1'b0, AW'((a + i) % DEPTH)});
        chk("rd_words", rq.size(), len + 1);
        for (int i = 0; i < rq.size() && i <= len; i++)
            chk("rd_word", {rq[i].last, rq[i].d}, {(i == len), ref_mem[(a + i) % DEPTH]});
        if (dq.size() > 0 && rq.size() > 0) chk("rd_done_cyc", dq[0], rq[rq.size() - 1].cyc + 1);
        if (mode == 0 && rq.size() > 0) chk("rd_first_latency", rq[0].cyc - acc, 3);
        if (mode == 2) begin
            cnt = 0;
            foreach (sq[i]) if (sq[i].cyc <= acc + stall_n) cnt++;
            chk("rd_stall_strobes", cnt, 2);
        end
        chk("rd_idle", {out_busy, out_cmd_ready}, 2'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int a, len, acc, n;
        in_reset_n = 1'b0; ram_clear = 1'b1;
        in_cmd_valid = 1'b0; in_cmd_write = 1'b0; in_cmd_address = '0; in_cmd_length = '0;
        in_wdata_valid = 1'b0; in_wdata = '0; in_rdata_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // 1: reset
        repeat (2) @(posedge in_clock);
        @(negedge in_clock);
        chk("reset_outputs", {out_cmd_ready, out_wdata_ready, out_rdata_valid, out_rdata,
                              out_rdata_last, out_done, out_busy, out_mem_enable,
                              out_mem_write, out_mem_address, out_mem_data}, 0);
        @(posedge in_clock); #1;
        in_reset_n = 1'b1; ram_clear = 1'b0;
        @(negedge in_clock);
        chk("post_reset_ready_busy", {out_cmd_ready, out_busy}, 2'b10);
        @(posedge in_clock); #1;

        // 2: write burst, back-to-back beats
        wq = '{16'h1234, 16'hABCD, 16'h000F};
        run_write(10, 2, 0);

        // 3: read it back with ready held
        run_read(10, 2, 0, 0);

        // 4: read with consumer stalled
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back(16'(16'h5A00 + i * 16'h0111));
        run_write(0, 4, 0);
        run_read(0, 4, 2, 6);

        // 5: write across the address wrap, then read back
        wq = '{16'hBEEF, 16'hCAFE};
        run_write(1023, 1, 0);
        run_read(1023, 1, 0, 0);

        // random bursts with random valid/ready gaps
        for (int k = 0; k < 8; k++) begin
            a   = (k % 2 == 0) ? (1012 + $urandom_range(11)) : $urandom_range(DEPTH - 1);
            len = (k == 0) ? 0 : $urandom_range(12);
            wq.delete();
            for (int i = 0; i <= len; i++) wq.push_back(16'($urandom));
            run_write(a, len, 30);
            run_read(a, len, 1, 0);
        end

        // 6: reset in the middle of a read burst
        clear_logs();
        a = 1020;
        in_rdata_ready = 1'b1;
        send_cmd(1'b0, a, 7, acc);
        n = 0;
        while (rq.size() < 2 && n < 100) begin
            @(negedge in_clock);
            @(posedge in_clock); #1;
            n++;
        end
        chk("abort_words_before", rq.size(), 2);
        for (int i = 0; i < rq.size() && i < 2; i++)
            chk("abort_word", {rq[i].last, rq[i].d}, {1'b0, ref_mem[(a + i) % DEPTH]});
        in_reset_n = 1'b0;
        @(posedge in_clock);
        @(negedge in_clock);
        chk("abort_quiet", {out_mem_enable, out_rdata_valid, out_done, out_cmd_ready}, 0);
        @(posedge in_clock); #1;
        clear_logs();
        in_reset_n = 1'b1;
        @(negedge in_clock);
        chk("abort_ready", {out_cmd_ready, out_busy}, 2'b10);
        repeat (10) @(posedge in_clock); #1;
        chk("abort_no_strobe", sq.size(), 0);
        chk("abort_no_stale_word", rq.size(), 0);
        chk("abort_no_done", dq.size(), 0);

        // normal operation after the abort
        run_read(a, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
